cfg_cbit_loader: RTL and testbench



---
 rtl/cfg_cbit_loader_pkg.sv | 34 +++
 rtl/cfg_cbit_loader_if.sv | 14 +
 rtl/cfg_cbit_loader_bank.sv | 50 +++++
 rtl/cfg_cbit_loader.sv | 187 ++++++++++++++++++
 tb/tb_cfg_cbit_loader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_cbit_loader_pkg.sv
// cfg_loader_pkg: shared types and constants for the cbit configuration loader.
//   state_t     - frame parser states
//   cell_wr_t   - one 2-bit cell write lane into the shadow bank
//   IDX_W       - width of cell index arithmetic (8-bit address plus carry)
package cfg_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      LEN    = 3'd2,
      DATA   = 3'd3,
      CHECK  = 3'd4,
      COMMIT = 3'd5
   } state_t;

   localparam logic [7:0]  HDR_BYTE_DEF   = 8'hA5;
   localparam int unsigned CELLS_PER_BYTE = 4;
   // One carry bit above the 8-bit address so addr+offset never wraps.
   localparam int unsigned IDX_W          = 9;
   // ceil(255/4) = 64 data bytes at most.
   localparam int unsigned LEFT_W         = 7;

   typedef struct packed {
      logic             we;
      logic [IDX_W-1:0] idx;
      logic [1:0]       data;
   } cell_wr_t;

   // Width able to hold any cell index of an array of n cells plus a flag bit.
   function automatic int unsigned cell_idx_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/cfg_cbit_loader_if.sv
// cfg_stream_if: byte stream into the loader.
//   in_data   - config byte
//   in_valid  - in_data valid
//   in_ready  - loader accepts byte this cycle
//   cfg_abort - synchronous frame abort
interface cfg_stream_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       cfg_abort;

   modport master (output in_data, output in_valid, output cfg_abort, input in_ready);
   modport slave  (input in_data, input in_valid, input cfg_abort, output in_ready);
endinterface

// File: rtl/cfg_cbit_loader_bank.sv
// cfg_cell_bank: shadow and active cbit register arrays.
//   snap_i   - copy active into shadow (frame start)
//   wr_i     - CELLS_PER_BYTE write lanes into shadow
//   commit_i - copy shadow into active in one edge
//   active_o - active cbits, cell i at [i]
module cfg_cell_bank
   import cfg_loader_pkg::*;
#(
   parameter int unsigned NUM_CELLS  = 16,
   parameter logic [1:0]  RESET_CBIT = 2'b00
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            snap_i,
   input  logic                            commit_i,
   input  cell_wr_t [CELLS_PER_BYTE-1:0]   wr_i,
   output logic [NUM_CELLS-1:0][1:0]       active_o
);

   logic [NUM_CELLS-1:0][1:0] shadow_q, shadow_d;
   logic [NUM_CELLS-1:0][1:0] active_q, active_d;

   // Snapshot and lane writes never coincide; commit reads the settled shadow.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (snap_i) shadow_d = active_q;
      for (int unsigned j = 0; j < CELLS_PER_BYTE; j++) begin
         if (wr_i[j].we) begin
            for (int unsigned c = 0; c < NUM_CELLS; c++) begin
               if (wr_i[j].idx == IDX_W'(c)) shadow_d[c] = wr_i[j].data;
            end
         end
      end
      if (commit_i) active_d = shadow_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         shadow_q <= {NUM_CELLS{RESET_CBIT}};
         active_q <= {NUM_CELLS{RESET_CBIT}};
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign active_o = active_q;

endmodule

// File: rtl/cfg_cbit_loader.sv
// cfg_cbit_loader: parses framed config bytes (HDR, ADDR, LEN, DATA.., CSUM)
// into a shadow bank and commits it atomically to the active cbit bus.
//   clk, resetn - clock, synchronous active-low reset
//   s           - byte stream (in_data/in_valid/in_ready/cfg_abort)
//   cbit_bus    - active cbits, cell i at [2i+1:2i]
//   cfg_busy    - frame in progress
//   cfg_done    - one-cycle pulse, frame committed
//   cfg_err     - one-cycle pulse, frame rejected
module cfg_cbit_loader
   import cfg_loader_pkg::*;
#(
   parameter int unsigned NUM_CELLS  = 16,
   parameter int unsigned CBIT_W     = 2,
   parameter logic [1:0]  RESET_CBIT = 2'b00,
   parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF
) (
   input  logic                          clk,
   input  logic                          resetn,
   cfg_stream_if.slave                   s,
   output logic [NUM_CELLS*CBIT_W-1:0]   cbit_bus,
   output logic                          cfg_busy,
   output logic                          cfg_done,
   output logic                          cfg_err
);

   state_t state_q, state_d;

   logic [7:0]        csum_q, csum_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [IDX_W-1:0]  off_q, off_d;
   logic [LEFT_W-1:0] left_q, left_d;
   logic              rerr_q, rerr_d;
   logic              match_q, match_d;

   logic ready_q, ready_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;

   logic fire_c, abort_c, hdr_c, snap_c, commit_c, commit_ok_c;
   logic [CELLS_PER_BYTE-1:0] oob_c;
   cell_wr_t [CELLS_PER_BYTE-1:0] wr_c;
   logic [NUM_CELLS-1:0][1:0] active_w;

   // Abort beats a same-cycle byte; COMMIT is not abortable.
   assign abort_c = s.cfg_abort && (state_q != COMMIT);
   assign fire_c  = s.in_valid && ready_q && !s.cfg_abort;
   assign hdr_c   = (s.in_data == HDR_BYTE);

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (abort_c) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:   if (fire_c && hdr_c) state_d = ADDR;
            ADDR:   if (fire_c) state_d = LEN;
            LEN:    if (fire_c) state_d = (s.in_data == 8'd0) ? CHECK : DATA;
            DATA:   if (fire_c && (left_q == LEFT_W'(1))) state_d = CHECK;
            CHECK:  if (fire_c) state_d = COMMIT;
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output / strobe logic
   always_comb begin
      snap_c      = (state_q == IDLE) && fire_c && hdr_c;
      commit_c    = (state_q == COMMIT);
      commit_ok_c = commit_c && match_q && !rerr_q;
      ready_d     = (state_d != COMMIT);
      busy_d      = (state_d != IDLE);
      done_d      = commit_ok_c;
      err_d       = commit_c && !commit_ok_c;
   end

   // Per-lane cell index; lanes past LEN are dead, lanes past the array flag range_err.
   always_comb begin
      wr_c  = '0;
      oob_c = '0;
      for (int unsigned j = 0; j < CELLS_PER_BYTE; j++) begin
         wr_c[j].idx  = IDX_W'(addr_q) + off_q + IDX_W'(j);
         wr_c[j].data = s.in_data[2*j +: 2];
         if ((state_q == DATA) && fire_c && ((off_q + IDX_W'(j)) < IDX_W'(len_q))) begin
            if (wr_c[j].idx < IDX_W'(NUM_CELLS)) wr_c[j].we = 1'b1;
            else                                 oob_c[j]   = 1'b1;
         end
      end
   end

   // Frame datapath: checksum, address, length, progress, error flags
   always_comb begin
      csum_d  = csum_q;
      addr_d  = addr_q;
      len_d   = len_q;
      off_d   = off_q;
      left_d  = left_q;
      rerr_d  = rerr_q;
      match_d = match_q;
      if (fire_c) begin
         case (state_q)
            IDLE: begin
               if (hdr_c) begin
                  csum_d  = 8'd0;
                  rerr_d  = 1'b0;
                  match_d = 1'b0;
               end
            end
            ADDR: begin
               addr_d = s.in_data;
               csum_d = csum_q ^ s.in_data;
            end
            LEN: begin
               len_d  = s.in_data;
               csum_d = csum_q ^ s.in_data;
               off_d  = '0;
               left_d = LEFT_W'((IDX_W'(s.in_data) + IDX_W'(3)) >> 2);
               if (s.in_data == 8'd0) rerr_d = 1'b1;
            end
            DATA: begin
               csum_d = csum_q ^ s.in_data;
               off_d  = off_q + IDX_W'(CELLS_PER_BYTE);
               left_d = left_q - LEFT_W'(1);
               if (|oob_c) rerr_d = 1'b1;
            end
            CHECK: match_d = (s.in_data == csum_q);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         csum_q  <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         off_q   <= '0;
         left_q  <= '0;
         rerr_q  <= 1'b0;
         match_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         csum_q  <= csum_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         off_q   <= off_d;
         left_q  <= left_d;
         rerr_q  <= rerr_d;
         match_q <= match_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   cfg_cell_bank #(
      .NUM_CELLS  (NUM_CELLS),
      .RESET_CBIT (RESET_CBIT)
   ) u_bank (
      .clk      (clk),
      .resetn   (resetn),
      .snap_i   (snap_c),
      .commit_i (commit_ok_c),
      .wr_i     (wr_c),
      .active_o (active_w)
   );

   assign s.in_ready = ready_q;
   assign cbit_bus   = active_w;
   assign cfg_busy   = busy_q;
   assign cfg_done   = done_q;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_cfg_cbit_loader.sv
// tb_cfg_cbit_loader: directed and randomized frames against a frame-level model.
module tb_cfg_cbit_loader;

   localparam int unsigned NUM_CELLS  = 16;
   localparam int unsigned W          = NUM_CELLS * 2;
   localparam logic [1:0]  RESET_CBIT = 2'b00;
   localparam logic [7:0]  HDR        = 8'hA5;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   cfg_stream_if s_if ();
   logic [W-1:0] cbit_bus;
   logic cfg_busy, cfg_done, cfg_err;

   cfg_cbit_loader #(
      .NUM_CELLS  (NUM_CELLS),
      .CBIT_W     (2),
      .RESET_CBIT (RESET_CBIT),
      .HDR_BYTE   (HDR)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .s        (s_if),
      .cbit_bus (cbit_bus),
      .cfg_busy (cfg_busy),
      .cfg_done (cfg_done),
      .cfg_err  (cfg_err)
   );

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit chk_en = 1'b0;

   // Frame-level model state
   logic [W-1:0] exp_bus, commit_bus;
   bit exp_ready, exp_busy, exp_done, exp_err, in_commit, commit_ok;
   logic [7:0] frame[$];
   logic [7:0] txq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole-frame evaluation once the last byte (checksum) has been taken.
   always @(posedge clk) begin : model
      bit rdy_prev;
      int unsigned a, n, x, idx;
      logic [7:0] b;
      rdy_prev = exp_ready;
      if (!resetn) begin
         exp_bus   = {NUM_CELLS{RESET_CBIT}};
         frame.delete();
         in_commit = 1'b0;
         exp_ready = 1'b0;
         exp_done  = 1'b0;
         exp_err   = 1'b0;
      end else begin
         exp_done = 1'b0;
         exp_err  = 1'b0;
         if (in_commit) begin
            in_commit = 1'b0;
            if (commit_ok) begin
               exp_bus  = commit_bus;
               exp_done = 1'b1;
            end else begin
               exp_err = 1'b1;
            end
            exp_ready = 1'b1;
         end else begin
            exp_ready = 1'b1;
            if (s_if.cfg_abort) begin
               frame.delete();
            end else if (s_if.in_valid && rdy_prev) begin
               if (frame.size() != 0 || s_if.in_data == HDR) frame.push_back(s_if.in_data);
               if (frame.size() >= 3 && frame.size() == 4 + (int'(frame[2]) + 3) / 4) begin
                  a = int'(frame[1]);
                  n = int'(frame[2]);
                  x = a ^ n;
                  for (int d = 3; d < frame.size() - 1; d++) x = x ^ int'(frame[d]);
                  commit_ok  = (x == int'(frame[frame.size()-1])) && (n != 0);
                  commit_bus = exp_bus;
                  for (int unsigned k = 0; k < n; k++) begin
                     idx = a + k;
                     if (idx >= NUM_CELLS) begin
                        commit_ok = 1'b0;
                     end else begin
                        b = frame[3 + k/4];
                        commit_bus[2*idx +: 2] = b[2*(k%4) +: 2];
                     end
                  end
                  in_commit = 1'b1;
                  exp_ready = 1'b0;
                  frame.delete();
               end
            end
         end
      end
      exp_busy = (frame.size() != 0) || in_commit;
   end

   // Every-cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cbit_bus", 64'(cbit_bus), 64'(exp_bus));
         check("in_ready", 64'(s_if.in_ready), 64'(exp_ready));
         check("cfg_busy", 64'(cfg_busy), 64'(exp_busy));
         check("cfg_done", 64'(cfg_done), 64'(exp_done));
         check("cfg_err", 64'(cfg_err), 64'(exp_err));
         if (cfg_done) done_cnt++;
         if (cfg_err) err_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      s_if.in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      s_if.in_valid = 1'b0;
      repeat (gap) tick();
      s_if.in_data  = b;
      s_if.in_valid = 1'b1;
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (s_if.in_ready) begin
            tick();
            s_if.in_valid = 1'b0;
            return;
         end
         tick();
      end
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
      s_if.in_valid = 1'b0;
   endtask

   task automatic send_frame(input int unsigned maxgap);
      for (int i = 0; i < txq.size(); i++) send_byte(txq[i], $urandom_range(0, maxgap));
   endtask

   task automatic abort_now(input bit with_byte, input logic [7:0] b);
      s_if.cfg_abort = 1'b1;
      s_if.in_valid  = with_byte;
      s_if.in_data   = b;
      tick();
      s_if.cfg_abort = 1'b0;
      s_if.in_valid  = 1'b0;
   endtask

   initial begin
      logic [7:0] addr, len, csum, d, garb;
      bit aborted;
      s_if.in_data   = 8'h00;
      s_if.in_valid  = 1'b0;
      s_if.cfg_abort = 1'b0;
      resetn = 1'b0;
      repeat (3) tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_bus", 64'(cbit_bus), 64'h0);
      check("rst_ready", 64'(s_if.in_ready), 64'h0);
      tick();
      resetn = 1'b1;
      idle(2);
      check("ready_after_rst", 64'(s_if.in_ready), 64'h1);

      // Good frame: cells 2..5 = 0,1,2,3
      txq = '{8'hA5, 8'h02, 8'h04, 8'hE4, 8'hE2};
      send_frame(0); idle(3);
      check("lit_good_bus", 64'(cbit_bus), 64'h0000_0E40);
      check("lit_good_model", 64'(exp_bus), 64'h0000_0E40);
      check("lit_good_done", 64'(done_cnt), 64'd1);

      // Bad checksum
      txq = '{8'hA5, 8'h02, 8'h04, 8'hE4, 8'h00};
      send_frame(0); idle(3);
      check("lit_badcs_bus", 64'(cbit_bus), 64'h0000_0E40);
      check("lit_badcs_err", 64'(err_cnt), 64'd1);

      // Out of range: cells 16,17
      txq = '{8'hA5, 8'h0E, 8'h04, 8'hFF, 8'hF5};
      send_frame(0); idle(3);
      check("lit_oob_bus", 64'(cbit_bus), 64'h0000_0E40);
      check("lit_oob_err", 64'(err_cnt), 64'd2);

      // Partial byte: only cell0 written
      txq = '{8'hA5, 8'h00, 8'h01, 8'h03, 8'h02};
      send_frame(0); idle(3);
      check("lit_partial_bus", 64'(cbit_bus), 64'h0000_0E43);

      // Zero length
      txq = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(0); idle(3);
      check("lit_len0_err", 64'(err_cnt), 64'd3);
      check("lit_len0_done", 64'(done_cnt), 64'd2);

      // Garbage then a good frame with stalls: cells 6..8 = 1
      txq = '{8'h11, 8'h22, 8'hA5, 8'h06, 8'h03, 8'h15, 8'h10};
      send_frame(2); idle(3);
      check("lit_garb_bus", 64'(cbit_bus), 64'h0001_5E43);

      // Abort during DATA (with a same-cycle byte), then a fresh frame
      txq = '{8'hA5, 8'h00, 8'h08, 8'hFF};
      send_frame(1);
      abort_now(1'b1, 8'h00);
      idle(2);
      check("lit_abort_bus", 64'(cbit_bus), 64'h0001_5E43);
      check("lit_abort_busy", 64'(cfg_busy), 64'h0);
      txq = '{8'hA5, 8'h0F, 8'h01, 8'h02, 8'h0C};
      send_frame(0); idle(3);
      check("lit_fresh_bus", 64'(cbit_bus), 64'h8001_5E43);

      // Abort during COMMIT is ignored
      txq = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00};
      send_frame(0);
      abort_now(1'b0, 8'h00);
      idle(2);
      check("lit_commit_abort_bus", 64'(cbit_bus), 64'h8001_5E41);
      check("lit_commit_abort_done", 64'(done_cnt), 64'd5);

      // Reset during DATA restores reset values
      txq = '{8'hA5, 8'h00, 8'h08, 8'hAA};
      send_frame(0);
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
      idle(2);
      check("lit_rst_mid_bus", 64'(cbit_bus), 64'h0);
      txq = '{8'hA5, 8'h02, 8'h04, 8'hE4, 8'hE2};
      send_frame(0); idle(3);
      check("lit_post_rst_bus", 64'(cbit_bus), 64'h0000_0E40);

      // Randomized frames
      for (int f = 0; f < 80; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            garb = 8'($urandom_range(0, 255));
            if (garb == HDR) garb = 8'h00;
            send_byte(garb, $urandom_range(0, 1));
         end
         addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                            : 8'($urandom_range(0, NUM_CELLS + 2));
         len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                            : 8'($urandom_range(0, 12));
         txq.delete();
         txq.push_back(HDR);
         txq.push_back(addr);
         txq.push_back(len);
         csum = addr ^ len;
         for (int i = 0; i < (int'(len) + 3) / 4; i++) begin
            d = 8'($urandom_range(0, 255));
            txq.push_back(d);
            csum = csum ^ d;
         end
         if ($urandom_range(0, 4) == 0) csum = csum ^ 8'($urandom_range(1, 255));
         txq.push_back(csum);
         aborted = 1'b0;
         for (int i = 0; i < txq.size() && !aborted; i++) begin
            if ($urandom_range(0, 24) == 0) begin
               abort_now(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
               aborted = 1'b1;
            end else begin
               send_byte(txq[i], $urandom_range(0, 2));
            end
         end
         idle($urandom_range(0, 2));
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
